counting_seq_gen: RTL and testbench

//   Stimulus-side counterpart of the 2-bit "01 -> 10 -> 11" sequence detector.

---
 rtl/counting_seq_gen.sv | 158 +++++++++++++++
 tb/tb_counting_seq_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/counting_seq_gen.sv
// counting_seq_gen -- burst generator feeding the 2-bit "01 -> 10 -> 11"
// sequence detector. One burst is len1 x 2'b01, len2 x 2'b10, len3 x 2'b11,
// after which num returns to its idle value 2'b00.
//
// Optional feature macro: COUNTING_GEN_LOOP_EN (adds the "loop" input and
// back-to-back repetition of the latched burst).
//
// Ports:
//   clk            clock, all state changes on posedge
//   reset          synchronous, active-high
//   start          burst request, accepted only in IDLE
//   loop           (COUNTING_GEN_LOOP_EN only) repeat burst with no 00 gap
//   len1/len2/len3 run lengths of 01/10/11; 0 skips that phase
//   num            registered symbol stream
//   busy           high while a symbol is being emitted
//   done           one-cycle end-of-burst pulse
module counting_seq_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef COUNTING_GEN_LOOP_EN
  input  logic             loop,
`endif
  input  logic [CNT_W-1:0] len1,
  input  logic [CNT_W-1:0] len2,
  input  logic [CNT_W-1:0] len3,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, RUN1, RUN2, RUN3, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] l1_q, l2_q, l3_q;
  logic             lat;
  logic             loop_s;
  logic             done_q;
  logic [2:0]       nz_q, nz_in, nz_src;

  // First phase strictly after position 'after' (0 = before RUN1) whose
  // length is nonzero; DONE when nothing remains.
  function automatic state_t pick(input logic [2:0] nz, input logic [1:0] after);
    if (after == 2'd0 && nz[0]) return RUN1;
    if (after <= 2'd1 && nz[1]) return RUN2;
    if (after <= 2'd2 && nz[2]) return RUN3;
    return DONE;
  endfunction

  function automatic logic [1:0] pos(input state_t s);
    case (s)
      RUN1:    return 2'd1;
      RUN2:    return 2'd2;
      RUN3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] len_of(input state_t s, input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] c);
    case (s)
      RUN1:    return a;
      RUN2:    return b;
      RUN3:    return c;
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] enc(input state_t s);
    case (s)
      RUN1:    return 2'b01;
      RUN2:    return 2'b10;
      RUN3:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

`ifdef COUNTING_GEN_LOOP_EN
  assign loop_s = loop;
`else
  assign loop_s = 1'b0;
`endif

  assign nz_in  = {len3 != '0, len2 != '0, len1 != '0};
  assign nz_q   = {l3_q != '0, l2_q != '0, l1_q != '0};
  // Lengths in force for the next state: fresh inputs on the accepting edge.
  assign nz_src = lat ? nz_in : nz_q;

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    lat     = 1'b0;
    case (state)
      IDLE: if (start) begin
        lat     = 1'b1;
        nxt     = pick(nz_in, 2'd0);
        nxt_cnt = len_of(nxt, len1, len2, len3);
      end
      RUN1, RUN2, RUN3: begin
        if (cnt == ONE) begin
          nxt = pick(nz_q, pos(state));
          // Looping restarts from the first nonzero phase with no idle gap.
          if (nxt == DONE && loop_s) nxt = pick(nz_q, 2'd0);
          nxt_cnt = len_of(nxt, l1_q, l2_q, l3_q);
        end else begin
          nxt_cnt = cnt - ONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

`ifdef COUNTING_GEN_LOOP_EN
  // High during the final cycle of the final phase; combined with loop so
  // that done rises alongside the last symbol when the burst repeats.
  logic last_q;
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= (nxt inside {RUN1, RUN2, RUN3}) && nxt_cnt == ONE &&
                         pick(nz_src, pos(nxt)) == DONE;
  end
  assign done = done_q | (last_q & loop);
`else
  assign done = done_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
      l3_q   <= '0;
      num    <= 2'b00;
      busy   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      if (lat) begin
        l1_q <= len1;
        l2_q <= len2;
        l3_q <= len3;
      end
      // Outputs are decoded from the next state so they are registered.
      num    <= enc(nxt);
      busy   <= nxt inside {RUN1, RUN2, RUN3};
      done_q <= nxt == DONE;
    end
  end

endmodule

// File: tb/tb_counting_seq_gen.sv
module tb_counting_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] len1 = '0, len2 = '0, len3 = '0;
  logic [1:0] num;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  counting_seq_gen #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .len1(len1), .len2(len2), .len3(len3),
    .num(num), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: when a burst is accepted, the whole visible output
  // stream {num,busy,done} is laid out in a queue from the run lengths:
  // len1 x 01, len2 x 10, len3 x 11 (busy=1), then one done cycle.
  // An empty queue with an idle current entry means the generator is idle.
  localparam logic [3:0] IDLE_E = 4'b0000;
  logic [3:0] q[$];
  logic [3:0] cur = IDLE_E;

  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      q.delete();
      cur = IDLE_E;
    end else if (cur == IDLE_E && q.size() == 0 && start) begin
      for (int i = 0; i < int'(len1); i++) q.push_back({2'b01, 2'b10});
      for (int i = 0; i < int'(len2); i++) q.push_back({2'b10, 2'b10});
      for (int i = 0; i < int'(len3); i++) q.push_back({2'b11, 2'b10});
      q.push_back({2'b00, 2'b01});
      cur = q.pop_front();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      cur = IDLE_E;
    end
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    start = st; len1 = a; len2 = b; len3 = c;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; len1 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({num, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset c%0d: num=%b busy=%b done=%b want 00 0 0", i, num, busy, done);
      end
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  // Runs one directed burst; exp_num is the spec's literal num trace.
  task automatic test_burst(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [1:0] exp_num[6]);
    drive(1'b1, a, b, c);
    cycle();
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cycle();
      checks++;
      if ({num, busy, done} !== cur) begin
        errors++;
        $display("FAIL %s model c%0d: got %b%b%b want %b", name, i, num, busy, done, cur);
      end
      checks++;
      if (num !== exp_num[i]) begin
        errors++;
        $display("FAIL %s trace c%0d: num=%b want %b", name, i, num, exp_num[i]);
      end
    end
  endtask

  task automatic test_ignore();
    drive(1'b1, 4'd3, 4'd2, 4'd2);
    cycle();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom));
      cycle();
      checks++;
      if ({num, busy, done} !== cur) begin
        errors++;
        $display("FAIL ignore c%0d: got %b%b%b want %b", i, num, busy, done, cur);
      end
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 40 && cur != IDLE_E; i++) cycle();
    cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd2, 4'd3, 4'd1);
    cycle();
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cycle();  // now in 2nd cycle of RUN2
    checks++;
    if ({num, busy} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid pre: num=%b busy=%b want 10 1", num, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    cycle();
    checks++;
    if ({num, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid: num=%b busy=%b done=%b want 00 0 0", num, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'd1, 4'd1, 4'd1);
    cycle();
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      checks++;
      if ({num, busy, done} !== cur) begin
        errors++;
        $display("FAIL rstmid restart c%0d: got %b%b%b want %b", i, num, busy, done, cur);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      len1  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      len2  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      len3  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      cycle();
      checks++;
      if ({num, busy, done} !== cur) begin
        errors++;
        $display("FAIL random c%0d: got %b%b%b want %b", i, num, busy, done, cur);
      end
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [1:0] t1[6] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [1:0] t2[6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [1:0] t3[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    test_reset();
    test_burst("len211", 4'd2, 4'd1, 4'd1, t1);
    test_burst("len103", 4'd1, 4'd0, 4'd3, t2);
    test_burst("len000", 4'd0, 4'd0, 4'd0, t3);
    test_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
